// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with a registered result behind a valid/ready handshake.
// Single-cycle ops finish in one clock; MUL iterates shift-add over WIDTH clocks.
module alu_exec_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       ALUControl,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero,
    output logic             illegal_op,
    output logic             busy
);

    localparam int SW = $clog2(WIDTH);
    localparam logic [SW:0] CNT_LAST = (SW+1)'(WIDTH - 1);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLL  = 4'b0101;
    localparam logic [3:0] OP_SRL  = 4'b0110;
    localparam logic [3:0] OP_SRA  = 4'b0111;
    localparam logic [3:0] OP_SLT  = 4'b1000;
    localparam logic [3:0] OP_SLTU = 4'b1001;
    localparam logic [3:0] OP_MUL  = 4'b1010;

    typedef enum logic {
        S_IDLE,
        S_MUL
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [SW:0]      cnt;

    logic [WIDTH-1:0] alu_res;
    logic             alu_illegal;
    logic [WIDTH-1:0] mul_sum;
    logic [SW-1:0]    shamt;
    logic             accept;

    assign busy     = (state == S_MUL);
    assign in_ready = (state == S_IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign shamt    = SrcB[SW-1:0];
    assign mul_sum  = acc + (mplier[0] ? mcand : '0);

    // Single-cycle datapath; MUL is handled by the iterative path below.
    always_comb begin
        alu_res     = '0;
        alu_illegal = 1'b0;
        case (ALUControl)
            OP_ADD:  alu_res = SrcA + SrcB;
            OP_SUB:  alu_res = SrcA - SrcB;
            OP_AND:  alu_res = SrcA & SrcB;
            OP_OR:   alu_res = SrcA | SrcB;
            OP_XOR:  alu_res = SrcA ^ SrcB;
            OP_SLL:  alu_res = SrcA << shamt;
            OP_SRL:  alu_res = SrcA >> shamt;
            OP_SRA:  alu_res = $signed(SrcA) >>> shamt;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (SrcA < SrcB)};
            OP_MUL:  alu_res = '0;
            default: alu_illegal = 1'b1;
        endcase
    end

    // A freshly written result overrides the consume-clear of out_valid on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            out_valid  <= 1'b0;
            ALUResult  <= '0;
            Zero       <= 1'b0;
            illegal_op <= 1'b0;
            acc        <= '0;
            mcand      <= '0;
            mplier     <= '0;
            cnt        <= '0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (ALUControl == OP_MUL) begin
                            acc    <= '0;
                            mcand  <= SrcA;
                            mplier <= SrcB;
                            cnt    <= '0;
                            state  <= S_MUL;
                        end else begin
                            ALUResult  <= alu_res;
                            Zero       <= (alu_res == '0);
                            illegal_op <= alu_illegal;
                            out_valid  <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    acc    <= mul_sum;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        ALUResult  <= mul_sum;
                        Zero       <= (mul_sum == '0);
                        illegal_op <= 1'b0;
                        out_valid  <= 1'b1;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed test-plan steps followed by
// randomized operations compared against an arithmetic reference model.
module tb_alu_exec_unit;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    ALUControl;
    logic [W-1:0]  SrcA;
    logic [W-1:0]  SrcB;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  ALUResult;
    logic          Zero;
    logic          illegal_op;
    logic          busy;

    int checks = 0;
    int errors = 0;

    alu_exec_unit #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ALUControl (ALUControl),
        .SrcA       (SrcA),
        .SrcB       (SrcB),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ALUResult  (ALUResult),
        .Zero       (Zero),
        .illegal_op (illegal_op),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Reference model written from the operation definitions, not the datapath.
    function automatic logic [31:0] refModel(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b, output logic ill);
        logic [4:0]  s;
        logic [31:0] fill;
        s   = b[4:0];
        ill = 1'b0;
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return a << s;
            4'd6:  return a >> s;
            4'd7: begin
                fill = a[31] ? ~(32'hFFFF_FFFF >> s) : 32'h0;
                return (a >> s) | fill;
            end
            4'd8:  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            4'd9:  return (a < b) ? 32'd1 : 32'd0;
            4'd10: return a * b;
            default: begin
                ill = 1'b1;
                return 32'd0;
            end
        endcase
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [3:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic ordy);
        in_valid   = v;
        ALUControl = op;
        SrcA       = a;
        SrcB       = b;
        out_ready  = ordy;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Issue one op from idle, wait for its result, optionally stall the consumer.
    task automatic runOp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int stall);
        logic [31:0] exp;
        logic        expIll;
        int          n;
        exp = refModel(op, a, b, expIll);
        applyStimulus(1'b1, op, a, b, 1'b1);
        checkOutput("in_ready_idle", in_ready, 1);
        tick;
        applyStimulus(1'b0, 4'd0, 32'h0, 32'h0, (stall > 0) ? 1'b0 : 1'b1);
        n = 1;
        while (out_valid !== 1'b1 && n < 40) begin
            checkOutput("mul_busy", busy, 1);
            checkOutput("mul_in_ready", in_ready, 0);
            tick;
            n++;
        end
        checkOutput("latency", n, (op == 4'd10) ? 33 : 1);
        checkOutput("result", ALUResult, exp);
        checkOutput("zero", Zero, (exp == 32'd0));
        checkOutput("illegal", illegal_op, expIll);
        checkOutput("busy_done", busy, 0);
        for (int s = 0; s < stall; s++) begin
            tick;
            checkOutput("hold_valid", out_valid, 1);
            checkOutput("hold_result", ALUResult, exp);
            checkOutput("hold_in_ready", in_ready, 0);
        end
        applyStimulus(1'b0, 4'd0, 32'h0, 32'h0, 1'b1);
        tick;
        checkOutput("consumed", out_valid, 0);
    endtask

    initial begin
        logic [31:0] expQ[$];
        logic [31:0] ea;
        logic [31:0] eb;
        logic        dummy;

        // Reset with in_valid high: nothing may be accepted.
        reset = 1'b1;
        applyStimulus(1'b1, 4'd0, 32'd1, 32'd1, 1'b1);
        tick;
        tick;
        reset = 1'b0;
        applyStimulus(1'b0, 4'd0, 32'h0, 32'h0, 1'b1);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_result", ALUResult, 0);
        checkOutput("rst_zero", Zero, 0);
        checkOutput("rst_illegal", illegal_op, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_in_ready", in_ready, 1);

        $display("[TB] directed operations");
        runOp(4'd0, 32'h7FFF_FFFF, 32'd1, 0);
        runOp(4'd1, 32'd5, 32'd5, 0);
        runOp(4'd7, 32'h8000_0000, 32'h24, 0);
        runOp(4'd6, 32'h8000_0000, 32'h24, 0);
        runOp(4'd8, 32'hFFFF_FFFF, 32'd1, 0);
        runOp(4'd9, 32'hFFFF_FFFF, 32'd1, 0);
        runOp(4'd10, 32'd12345, 32'd678, 0);
        checkOutput("mul_const", refModel(4'd10, 32'd12345, 32'd678, dummy), 32'd8369910);
        runOp(4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2);
        runOp(4'd12, 32'h1234_5678, 32'h9ABC_DEF0, 0);
        runOp(4'd2, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 0);

        $display("[TB] back-to-back throughput and stall");
        for (int i = 0; i < 6; i++) begin
            ea = $urandom;
            eb = $urandom;
            applyStimulus(1'b1, 4'd0, ea, eb, 1'b1);
            checkOutput("b2b_in_ready", in_ready, 1);
            if (i > 0) begin
                checkOutput("b2b_valid", out_valid, 1);
                checkOutput("b2b_result", ALUResult, expQ[i-1]);
            end
            expQ.push_back(ea + eb);
            tick;
        end
        ea = 32'd100;
        eb = 32'd23;
        applyStimulus(1'b1, 4'd1, ea, eb, 1'b0);
        for (int i = 0; i < 5; i++) begin
            checkOutput("stall_in_ready", in_ready, 0);
            checkOutput("stall_valid", out_valid, 1);
            checkOutput("stall_result", ALUResult, expQ[5]);
            tick;
        end
        applyStimulus(1'b1, 4'd1, ea, eb, 1'b1);
        checkOutput("release_in_ready", in_ready, 1);
        tick;
        applyStimulus(1'b0, 4'd0, 32'h0, 32'h0, 1'b1);
        checkOutput("release_valid", out_valid, 1);
        checkOutput("release_result", ALUResult, 32'd77);
        tick;
        checkOutput("release_consumed", out_valid, 0);

        $display("[TB] reset during MUL");
        applyStimulus(1'b1, 4'd10, 32'd12345, 32'd678, 1'b1);
        tick;
        applyStimulus(1'b0, 4'd0, 32'h0, 32'h0, 1'b1);
        for (int i = 0; i < 9; i++) tick;
        checkOutput("mid_mul_busy", busy, 1);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        #1;
        checkOutput("mulrst_valid", out_valid, 0);
        checkOutput("mulrst_busy", busy, 0);
        checkOutput("mulrst_result", ALUResult, 0);
        checkOutput("mulrst_in_ready", in_ready, 1);
        runOp(4'd0, 32'd2, 32'd3, 0);

        $display("[TB] randomized operations");
        for (int i = 0; i < 40; i++) begin
            runOp(4'($urandom_range(0, 15)), $urandom, ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom,
                  $urandom_range(0, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
